// File: rtl/armstrong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : armstrong_pkg
//  Purpose  : Shared defaults and scanner state encoding for the Armstrong
//             range scanner.
//  Revision : 1.0 - initial release
// ============================================================================
package armstrong_pkg;

   // Default candidate width, matching the combinational checker's num input
   localparam int NUM_W_DEFAULT = 10;

   // Scanner state encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

endpackage : armstrong_pkg
`default_nettype wire

// File: rtl/armstrong_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : armstrong_scanner_if
//  Purpose  : valid/ready stream carrying Armstrong hits out of the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
interface armstrong_scanner_if
   import armstrong_pkg::*;
#(
   parameter int NUM_W = NUM_W_DEFAULT
);
   logic             hit_valid;
   logic [NUM_W-1:0] hit_num;
   logic             hit_ready;

   // Scanner side: presents hits
   modport master (
      output hit_valid,
      output hit_num,
      input  hit_ready
   );

   // Downstream side: consumes hits
   modport slave (
      input  hit_valid,
      input  hit_num,
      output hit_ready
   );
endinterface : armstrong_scanner_if
`default_nettype wire

// File: rtl/armstrong_scanner_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hit_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO buffering scanner hits.
//             Head is visible on dout whenever not empty; while empty dout
//             holds the most recently popped word.
//  Revision : 1.0 - initial release
// ============================================================================
module hit_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] din,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int c_ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [c_ADDR_W:0] r_wr_ptr;
   logic [c_ADDR_W:0] r_rd_ptr;
   logic [WIDTH-1:0]  r_last;
   logic              w_do_push;
   logic              w_do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                      (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = empty ? r_last : r_mem[r_rd_ptr[c_ADDR_W-1:0]];

   // Storage array: written on accepted pushes only, needs no reset
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= din;
      end
   end

   // Pointer bookkeeping and last-popped capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_last   <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
         end
      end
   end

endmodule : hit_fifo
`default_nettype wire

// File: rtl/armstrong_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : armstrong_scanner
//  Purpose  : Walks candidates lo..hi one per cycle past an external
//             combinational Armstrong checker, buffers the hits and streams
//             them out on a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module armstrong_scanner
   import armstrong_pkg::*;
#(
   parameter int NUM_W = NUM_W_DEFAULT,
   parameter int DEPTH = 8,
   parameter int CNT_W = 5
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             start,
   input  wire logic [NUM_W-1:0] lo,
   input  wire logic [NUM_W-1:0] hi,
   output logic      [NUM_W-1:0] num_out,
   input  wire logic             isarm_in,
   output logic                  busy,
   output logic                  done,
   output logic      [CNT_W-1:0] hit_count,
   armstrong_scanner_if.master   hs
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [NUM_W-1:0] c_ONE     = {{(NUM_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [NUM_W-1:0] r_num;
   logic [NUM_W-1:0] r_hi;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_scan;
   logic             w_push;
   logic             w_advance;
   logic             w_pop;

   assign w_scan    = (r_state == SCAN);
   // A hit is only recorded when there is room; a full FIFO stalls the scan
   // even if the downstream pops on the same edge
   assign w_push    = w_scan && isarm_in && !w_full;
   assign w_advance = w_scan && (!isarm_in || !w_full);
   assign w_pop     = hs.hit_valid && hs.hit_ready;

   assign num_out      = r_num;
   assign busy         = w_scan;
   assign done         = (r_state == FIN);
   assign hit_count    = r_count;
   assign hs.hit_valid = !w_empty;

   hit_fifo #(
      .WIDTH (NUM_W),
      .DEPTH (DEPTH)
   ) u_hit_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (r_num),
      .pop   (w_pop),
      .dout  (hs.hit_num),
      .full  (w_full),
      .empty (w_empty)
   );

   // Scan sequencer: candidate counter, hit counter and state transitions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_num   <= '0;
         r_hi    <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_count <= '0;
                  if (lo <= hi) begin
                     r_num   <= lo;
                     r_hi    <= hi;
                     r_state <= SCAN;
                  end else begin
                     r_state <= FIN;
                  end
               end
            end
            SCAN: begin
               if (w_push && (r_count != c_CNT_MAX)) begin
                  r_count <= r_count + 1'b1;
               end
               // Test for the last candidate before incrementing so a scan
               // ending at the top of the range never wraps
               if (w_advance) begin
                  if (r_num == r_hi) begin
                     r_state <= FIN;
                  end else begin
                     r_num <= r_num + c_ONE;
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : armstrong_scanner
`default_nettype wire

// File: tb/tb_armstrong_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_armstrong_scanner
//  Purpose  : Bench for armstrong_scanner with a behavioural Armstrong
//             checker on isarm_in and a queue-based hit scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_armstrong_scanner;

   localparam int NUM_W = 10;
   localparam int DEPTH = 8;
   localparam int CNT_W = 5;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [NUM_W-1:0] lo;
   logic [NUM_W-1:0] hi;
   logic [NUM_W-1:0] num_out;
   logic             isarm_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] hit_count;

   armstrong_scanner_if #(.NUM_W(NUM_W)) hs ();

   armstrong_scanner #(
      .NUM_W (NUM_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .lo        (lo),
      .hi        (hi),
      .num_out   (num_out),
      .isarm_in  (isarm_in),
      .busy      (busy),
      .done      (done),
      .hit_count (hit_count),
      .hs        (hs.master)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural Armstrong checker: sum of digits each raised to the digit count
   function automatic logic is_armstrong(input int n);
      int digits;
      int t;
      int sum;
      int d;
      int p;
      digits = 0;
      t = n;
      do begin
         digits++;
         t = t / 10;
      end while (t != 0);
      sum = 0;
      t = n;
      do begin
         d = t % 10;
         p = 1;
         for (int k = 0; k < digits; k++) p = p * d;
         sum = sum + p;
         t = t / 10;
      end while (t != 0);
      return (sum == n);
   endfunction

   always_comb isarm_in = is_armstrong(int'(num_out));

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   // Monitor: each accepted hit is compared against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && hs.hit_valid && hs.hit_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_hit", int'(hs.hit_num), -1);
         end else begin
            chk("hit_num", int'(hs.hit_num), exp_q.pop_front());
         end
      end
   end

   // Called #1 after a rising edge; start is sampled on the next edge (E0)
   task automatic pulse_start(input int l, input int h);
      start = 1'b1;
      lo    = NUM_W'(l);
      hi    = NUM_W'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, int'(done), 1);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Stimulus and directed checks
   initial begin
      int n;
      int dcnt;
      int bseen;
      int vseen;
      rst_n        = 1'b0;
      start        = 1'b0;
      lo           = '0;
      hi           = '0;
      hs.hit_ready = 1'b0;
      cycles(2);
      chk("rst_num_out",   int'(num_out),      0);
      chk("rst_busy",      int'(busy),         0);
      chk("rst_done",      int'(done),         0);
      chk("rst_hit_count", int'(hit_count),    0);
      chk("rst_hit_valid", int'(hs.hit_valid), 0);
      chk("rst_hit_num",   int'(hs.hit_num),   0);
      rst_n = 1'b1;
      cycles(1);

      // Range 0..20, always ready: hits 0..9, done after E21
      hs.hit_ready = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      pulse_start(0, 20);
      for (int i = 1; i <= 21; i++) begin
         @(posedge clk); #1;
         if (i == 20) begin
            chk("s1_done_early", int'(done), 0);
            chk("s1_busy_mid",   int'(busy), 1);
         end
      end
      chk("s1_done",      int'(done),      1);
      chk("s1_busy_fin",  int'(busy),      0);
      chk("s1_hit_count", int'(hit_count), 10);
      cycles(1);
      chk("s1_done_pulse", int'(done), 0);
      chk("s1_busy_idle",  int'(busy), 0);
      cycles(3);
      chk("s1_drained", exp_q.size(), 0);

      // Range 100..500 with a start re-pulse mid-scan that must be ignored
      exp_q.push_back(153);
      exp_q.push_back(370);
      exp_q.push_back(371);
      exp_q.push_back(407);
      pulse_start(100, 500);
      cycles(100);
      pulse_start(0, 20);
      wait_done("s2_done", 600);
      chk("s2_hit_count", int'(hit_count), 4);
      chk("s2_num_hold",  int'(num_out),   500);
      cycles(3);
      chk("s2_drained", exp_q.size(), 0);

      // Full range with downstream stalled: scan blocks at candidate 8
      hs.hit_ready = 1'b0;
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      exp_q.push_back(153);
      exp_q.push_back(370);
      exp_q.push_back(371);
      exp_q.push_back(407);
      pulse_start(0, 1023);
      cycles(20);
      chk("s3_stall_num",   int'(num_out),      8);
      chk("s3_stall_busy",  int'(busy),         1);
      chk("s3_stall_count", int'(hit_count),    8);
      chk("s3_stall_valid", int'(hs.hit_valid), 1);
      chk("s3_stall_head",  int'(hs.hit_num),   0);
      hs.hit_ready = 1'b1;
      wait_done("s3_done", 1200);
      chk("s3_num_end",   int'(num_out),   1023);
      chk("s3_hit_count", int'(hit_count), 14);
      cycles(3);
      chk("s3_num_nowrap", int'(num_out), 1023);
      chk("s3_drained",    exp_q.size(),  0);

      // Empty range: single done pulse, never busy, no hits
      dcnt  = 0;
      bseen = 0;
      vseen = 0;
      pulse_start(5, 3);
      for (int i = 0; i < 6; i++) begin
         if (done) dcnt++;
         if (busy) bseen = 1;
         if (hs.hit_valid) vseen = 1;
         @(posedge clk); #1;
      end
      chk("s4_done_pulses", dcnt,  1);
      chk("s4_busy_seen",   bseen, 0);
      chk("s4_valid_seen",  vseen, 0);

      // Asynchronous reset mid-scan at candidate 200, then a fresh scan
      for (int i = 0; i < 10; i++) exp_q.push_back(i);
      exp_q.push_back(153);
      pulse_start(0, 1023);
      n = 0;
      while (num_out != NUM_W'(200) && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("s5_reached_200", int'(num_out), 200);
      chk("s5_pre_drained", exp_q.size(),  0);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_num_out",   int'(num_out),      0);
      chk("s5_rst_busy",      int'(busy),         0);
      chk("s5_rst_done",      int'(done),         0);
      chk("s5_rst_hit_count", int'(hit_count),    0);
      chk("s5_rst_hit_valid", int'(hs.hit_valid), 0);
      chk("s5_rst_hit_num",   int'(hs.hit_num),   0);
      #1;
      rst_n = 1'b1;
      cycles(2);
      exp_q.push_back(153);
      pulse_start(150, 160);
      wait_done("s5_done", 40);
      chk("s5_hit_count", int'(hit_count), 1);
      cycles(3);
      chk("s5_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_armstrong_scanner
`default_nettype wire
